wb_port_arbiter: RTL and testbench

//  Owns the single register-file write port. Arbitrates between the in-order

---
 rtl/wb_port_arbiter.sv | 145 ++++++++++++++
 tb/tb_wb_port_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//   Owns the single register-file write port. The in-order writeback result
//   (wb_*) has priority; results from a multi-cycle unit (mc_*) are queued in a
//   DEPTH-entry FIFO and drain into free write slots. If the pipeline keeps the
//   port busy for MAX_WAIT cycles while entries are queued, stall_req_o freezes
//   the pipeline for one cycle and the FIFO head is written instead.
// Ports
//   clk_i, rst_i                    clock, synchronous active-high reset
//   wb_we_i/wb_rd_i/wb_result_i/wb_vector_op_i   writeback write request
//   mc_valid_i/mc_ready_o/mc_rd_i/mc_data_i/mc_vector_i   mc result handshake
//   rf_we_o/rf_waddr_o/rf_wdata_o   register-file write port (combinational)
//   stall_req_o                     one-cycle pipeline freeze for forced drain
//   pending_mask_o                  registers targeted by queued mc writes
module wb_port_arbiter #(
  parameter int DATA_W   = 128,
  parameter int REG_AW   = 5,
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wb_we_i,
  input  logic [REG_AW-1:0] wb_rd_i,
  input  logic [DATA_W-1:0] wb_result_i,
  input  logic              wb_vector_op_i,
  input  logic              mc_valid_i,
  output logic              mc_ready_o,
  input  logic [REG_AW-1:0] mc_rd_i,
  input  logic [DATA_W-1:0] mc_data_i,
  input  logic              mc_vector_i,
  output logic              rf_we_o,
  output logic [REG_AW-1:0] rf_waddr_o,
  output logic [DATA_W-1:0] rf_wdata_o,
  output logic              stall_req_o,
  output logic [31:0]       pending_mask_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int WW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {IDLE, PEND, FORCE} state_t;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] data;
    logic              vec;
  } ent_t;

  ent_t              mem_q [DEPTH];
  logic [DEPTH-1:0]  vld_q;
  logic [PW-1:0]     rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WW-1:0]     wait_q, wait_d;
  state_t            state_q, state_d;

  logic push, pop, pipe_wr, full;
  ent_t head;

  // Scalar writes replicate lane 0 across all 32-bit lanes.
  function automatic logic [DATA_W-1:0] fmt(input logic [DATA_W-1:0] d, input logic vec);
    return vec ? d : {(DATA_W/32){d[31:0]}};
  endfunction

  assign full       = (cnt_q == CW'(DEPTH));
  assign mc_ready_o = !full && !rst_i;
  assign push       = mc_valid_i && mc_ready_o;
  assign pipe_wr    = wb_we_i && (wb_rd_i != '0);
  assign head       = mem_q[rd_ptr_q];

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    pop         = 1'b0;
    stall_req_o = 1'b0;
    case (state_q)
      IDLE: if (push) state_d = PEND;
      PEND: begin
        if (!pipe_wr) begin
          pop    = 1'b1;
          wait_d = '0;
        end else begin
          wait_d = (wait_q == WW'(MAX_WAIT)) ? wait_q : wait_q + 1'b1;
          if (wait_q == WW'(MAX_WAIT - 1)) state_d = FORCE;
        end
      end
      FORCE: begin
        stall_req_o = 1'b1;
        pop         = 1'b1;
        wait_d      = '0;
      end
      default: state_d = IDLE;
    endcase
    cnt_d = cnt_q + CW'(push) - CW'(pop);
    // Any pop re-evaluates occupancy: drained -> IDLE, otherwise keep draining.
    if (pop) state_d = (cnt_d == '0) ? IDLE : PEND;
    if (rst_i) stall_req_o = 1'b0;
  end

  // Write port: popped head (x0 entries discarded) or the pipeline.
  always_comb begin
    if (pop) begin
      rf_we_o    = (head.rd != '0);
      rf_waddr_o = head.rd;
      rf_wdata_o = fmt(head.data, head.vec);
    end else begin
      rf_we_o    = pipe_wr;
      rf_waddr_o = wb_rd_i;
      rf_wdata_o = fmt(wb_result_i, wb_vector_op_i);
    end
    if (rst_i) rf_we_o = 1'b0;
  end

  always_comb begin
    pending_mask_o = '0;
    for (int i = 0; i < DEPTH; i++)
      if (vld_q[i]) pending_mask_o = pending_mask_o | (32'(1) << mem_q[i].rd);
    pending_mask_o[0] = 1'b0;
    if (rst_i) pending_mask_o = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      wait_q   <= '0;
      cnt_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      vld_q    <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
      // push and pop never hit the same slot: push needs !full, pop needs !empty.
      if (pop) begin
        vld_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q        <= rd_ptr_q + 1'b1;
      end
      if (push) begin
        mem_q[wr_ptr_q] <= '{rd: mc_rd_i, data: mc_data_i, vec: mc_vector_i};
        vld_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;
  localparam int DW = 128, AW = 5, DEPTH = 4, MAXW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, wb_we, wb_vec, mc_valid, mc_vec;
  logic [AW-1:0] wb_rd, mc_rd;
  logic [DW-1:0] wb_d, mc_d;
  logic          mc_ready, rf_we, stall_req;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [31:0]   pending_mask;

  wb_port_arbiter #(.DATA_W(DW), .REG_AW(AW), .DEPTH(DEPTH), .MAX_WAIT(MAXW)) dut (
    .clk_i(clk), .rst_i(rst), .wb_we_i(wb_we), .wb_rd_i(wb_rd), .wb_result_i(wb_d),
    .wb_vector_op_i(wb_vec), .mc_valid_i(mc_valid), .mc_ready_o(mc_ready),
    .mc_rd_i(mc_rd), .mc_data_i(mc_d), .mc_vector_i(mc_vec), .rf_we_o(rf_we),
    .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata), .stall_req_o(stall_req),
    .pending_mask_o(pending_mask));

  typedef struct {
    logic [AW-1:0] rd;
    logic [DW-1:0] d;
    logic          v;
  } ent_t;

  // Reference model: queue contents, cycles the head has been blocked, and
  // whether the next cycle must be a forced drain.
  ent_t q[$];
  int   wt;
  bit   frc;
  int   total, bad;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] fmt(input logic [DW-1:0] d, input logic v);
    return v ? d : {4{d[31:0]}};
  endfunction

  // Called just after a rising edge with this cycle's inputs driven; checks at
  // the falling edge, advances the model, returns 1 unit after the next edge.
  task automatic step();
    logic          ewe, erdy, estall, pipe;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic [31:0]   em;
    bit            popq;
    ent_t          h;
    @(negedge clk);
    ewe = 0; ea = '0; ed = '0; estall = 0; em = '0; popq = 0;
    erdy = !rst && (q.size() < DEPTH);
    pipe = wb_we && (wb_rd != 0);
    if (!rst) begin
      foreach (q[i]) em[q[i].rd] = 1'b1;
      em[0] = 1'b0;
      if (q.size() == 0) begin
        ewe = pipe; ea = wb_rd; ed = fmt(wb_d, wb_vec);
      end else if (frc || !pipe) begin
        popq = 1; estall = frc; h = q[0];
        ewe = (h.rd != 0); ea = h.rd; ed = fmt(h.d, h.v);
      end else begin
        ewe = 1; ea = wb_rd; ed = fmt(wb_d, wb_vec);
      end
    end
    chk("rf_we", rf_we, ewe);
    chk("mc_ready", mc_ready, erdy);
    chk("stall_req", stall_req, estall);
    chk("pending_mask", pending_mask, em);
    if (ewe) begin
      chk("rf_waddr", rf_waddr, ea);
      chk("rf_wdata", rf_wdata, ed);
    end
    if (rst) begin
      q.delete(); wt = 0; frc = 0;
    end else begin
      if (popq) begin
        void'(q.pop_front()); wt = 0; frc = 0;
      end else if (q.size() != 0) begin
        wt++;
        if (wt == MAXW) frc = 1;
      end
      if (mc_valid && erdy) q.push_back('{rd: mc_rd, d: mc_d, v: mc_vec});
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int order[$];
    int n;
    total = 0; bad = 0; wt = 0; frc = 0;
    rst = 1; wb_we = 0; wb_rd = '0; wb_d = '0; wb_vec = 0;
    mc_valid = 1; mc_rd = 5'd1; mc_d = '0; mc_vec = 0;
    @(posedge clk); #1;

    // Reset held two cycles with mc_valid asserted.
    step(); step();
    rst = 0; mc_valid = 0; #1;
    chk("t1_ready", mc_ready, 1'b1);
    chk("t1_pm", pending_mask, 32'h0);
    chk("t1_stall", stall_req, 1'b0);
    step();

    // Idle pipeline, single scalar push drains the next cycle.
    mc_valid = 1; mc_rd = 5'd5; mc_d = {96'h0123_4567_89ab_cdef_0011_2233, 32'hDEADBEEF};
    step();
    mc_valid = 0; #1;
    chk("t2_we", rf_we, 1'b1);
    chk("t2_addr", rf_waddr, 5'd5);
    chk("t2_data", rf_wdata, {4{32'hDEADBEEF}});
    chk("t2_pm", pending_mask[5], 1'b1);
    step(); #1;
    chk("t2_pm0", pending_mask, 32'h0);
    step();

    // Busy pipeline: MAX_WAIT blocked cycles, then a forced drain.
    wb_we = 1; wb_rd = 5'd3; wb_d = {4{32'h33333333}}; wb_vec = 1;
    mc_valid = 1; mc_rd = 5'd7; mc_vec = 1; mc_d = {4{32'h77777777}};
    step();
    mc_valid = 0;
    for (int i = 0; i < MAXW; i++) begin
      #1 chk("t3_pipe", rf_waddr, 5'd3);
      step();
    end
    #1;
    chk("t3_stall", stall_req, 1'b1);
    chk("t3_addr", rf_waddr, 5'd7);
    step(); #1;
    chk("t3_back", rf_waddr, 5'd3);
    chk("t3_nostall", stall_req, 1'b0);
    step();

    // Fill the FIFO behind a busy pipeline; fifth entry waits for space.
    for (int k = 1; k <= 4; k++) begin
      mc_valid = 1; mc_rd = AW'(k); mc_d = DW'(k);
      step();
    end
    mc_rd = 5'd5; mc_d = DW'(5); #1;
    chk("t4_full", mc_ready, 1'b0);
    n = 0;
    while (order.size() < 5 && n < 100) begin
      bit acc;
      #1;
      acc = mc_valid && mc_ready;
      if (stall_req) order.push_back(int'(rf_waddr));
      step();
      if (acc) mc_valid = 0;
      n++;
    end
    chk("t4_cnt", DW'(order.size()), DW'(5));
    foreach (order[i]) chk("t4_order", DW'(order[i]), DW'(i + 1));
    step();

    // x0 handling on both sources.
    wb_we = 1; wb_rd = 5'd0;
    mc_valid = 1; mc_rd = 5'd9; mc_vec = 0;
    step();
    mc_valid = 0; #1;
    chk("t5_we", rf_we, 1'b1);
    chk("t5_addr", rf_waddr, 5'd9);
    step();
    mc_valid = 1; mc_rd = 5'd0;
    step();
    mc_valid = 0; #1;
    chk("t5_x0_we", rf_we, 1'b0);
    step(); step();

    // Reset with three entries queued.
    wb_rd = 5'd3;
    for (int k = 0; k < 3; k++) begin
      mc_valid = 1; mc_rd = AW'(10 + k);
      step();
    end
    mc_valid = 0; rst = 1;
    step();
    rst = 0; wb_we = 0; #1;
    chk("t6_pm", pending_mask, 32'h0);
    chk("t6_we", rf_we, 1'b0);
    step(); step();

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      rst      = ($urandom_range(199) == 0);
      wb_we    = ($urandom_range(99) < 75);
      wb_rd    = AW'($urandom_range(31));
      wb_vec   = $urandom_range(1);
      wb_d     = {$urandom, $urandom, $urandom, $urandom};
      mc_valid = ($urandom_range(99) < 40);
      mc_rd    = ($urandom_range(15) == 0) ? '0 : AW'($urandom_range(31));
      mc_vec   = $urandom_range(1);
      mc_d     = {$urandom, $urandom, $urandom, $urandom};
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
